// File: rtl/sn74145_bcd_decoder_if.sv
// rtl/sn74145_bcd_decoder_if.sv - BCD code, chip-select and decimal-output bundle for the SN74145 decoder
//
// Purpose: groups the decoder's data-side signals so that the driver and the
//          decoder connect through one port.
// Signals:
//   i_a..i_d            BCD code, i_a is the LSB
//   i_cs                chip select, active-high
//   i_n_cs_0, i_n_cs_1  chip selects, active-low
//   o_0..o_9            registered decimal outputs
// Modports:
//   master  drives the code and selects, observes the outputs
//   slave   the decoder: samples the code and selects, drives the outputs

interface sn74145_bcd_decoder_if;
    logic i_a;
    logic i_b;
    logic i_c;
    logic i_d;
    logic i_cs;
    logic i_n_cs_0;
    logic i_n_cs_1;
    logic o_0;
    logic o_1;
    logic o_2;
    logic o_3;
    logic o_4;
    logic o_5;
    logic o_6;
    logic o_7;
    logic o_8;
    logic o_9;

    modport master (
        output i_a, i_b, i_c, i_d, i_cs, i_n_cs_0, i_n_cs_1,
        input  o_0, o_1, o_2, o_3, o_4, o_5, o_6, o_7, o_8, o_9
    );

    modport slave (
        input  i_a, i_b, i_c, i_d, i_cs, i_n_cs_0, i_n_cs_1,
        output o_0, o_1, o_2, o_3, o_4, o_5, o_6, o_7, o_8, o_9
    );
endinterface

// File: rtl/sn74145_bcd_decoder.sv
// rtl/sn74145_bcd_decoder.sv - registered BCD-to-decimal 1-of-10 decoder modelled on the SN74145
//
// Purpose: decodes the 4-bit BCD code {i_d,i_c,i_b,i_a} to ten one-hot
//          outputs, gated by a three-term chip select, with one cycle of
//          latency through the output register.
// Parameters:
//   OUT_ACTIVE_LOW  1: selected output is 0, others 1; 0: every level inverted
// Ports:
//   i_clk  clock, all state updates on the rising edge
//   i_rst  synchronous active-high reset, forces all outputs to the idle level
//   bus    sn74145_bcd_decoder_if.slave: code, chip selects, o_0..o_9

module sn74145_bcd_decoder #(
    parameter bit OUT_ACTIVE_LOW = 1'b1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    sn74145_bcd_decoder_if.slave        bus
);

    // Idle level of every output: all 1 for active-low outputs, all 0 otherwise.
    localparam logic [9:0] IDLE_LEVEL = {10{OUT_ACTIVE_LOW}};

    logic [3:0] code;
    logic       en;
    logic [9:0] sel;
    logic [9:0] out_d;
    logic [9:0] out_q;

    assign code = {bus.i_d, bus.i_c, bus.i_b, bus.i_a};
    assign en   = bus.i_cs & ~bus.i_n_cs_0 & ~bus.i_n_cs_1;

    // Active-high one-hot select; codes 10..15 select nothing rather than
    // folding onto a lower output.
    always_comb begin
        sel = '0;
        if (en && (code <= 4'd9)) begin
            sel = 10'd1 << code;
        end
    end

    always_comb begin
        out_d = OUT_ACTIVE_LOW ? ~sel : sel;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_q <= IDLE_LEVEL;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.o_0 = out_q[0];
    assign bus.o_1 = out_q[1];
    assign bus.o_2 = out_q[2];
    assign bus.o_3 = out_q[3];
    assign bus.o_4 = out_q[4];
    assign bus.o_5 = out_q[5];
    assign bus.o_6 = out_q[6];
    assign bus.o_7 = out_q[7];
    assign bus.o_8 = out_q[8];
    assign bus.o_9 = out_q[9];

endmodule

// File: tb/tb_sn74145_bcd_decoder.sv
// tb/tb_sn74145_bcd_decoder.sv - scoreboard bench for the SN74145 decoder in both output polarities

module tb_sn74145_bcd_decoder;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    sn74145_bcd_decoder_if bus_lo ();
    sn74145_bcd_decoder_if bus_hi ();

    sn74145_bcd_decoder #(.OUT_ACTIVE_LOW(1'b1)) u_dut_lo (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_lo.slave)
    );

    sn74145_bcd_decoder #(.OUT_ACTIVE_LOW(1'b0)) u_dut_hi (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_hi.slave)
    );

    function automatic logic [9:0] out_lo();
        return {bus_lo.o_9, bus_lo.o_8, bus_lo.o_7, bus_lo.o_6, bus_lo.o_5,
                bus_lo.o_4, bus_lo.o_3, bus_lo.o_2, bus_lo.o_1, bus_lo.o_0};
    endfunction

    function automatic logic [9:0] out_hi();
        return {bus_hi.o_9, bus_hi.o_8, bus_hi.o_7, bus_hi.o_6, bus_hi.o_5,
                bus_hi.o_4, bus_hi.o_3, bus_hi.o_2, bus_hi.o_1, bus_hi.o_0};
    endfunction

    // v = {i_n_cs_1, i_n_cs_0, i_cs, i_d, i_c, i_b, i_a}. Drives both decoders,
    // pushes the active-low expectation, then advances past one rising edge.
    task automatic drive(input logic r, input logic [6:0] v);
        logic [9:0] e;
        logic [3:0] c;
        rst = r;
        {bus_lo.i_n_cs_1, bus_lo.i_n_cs_0, bus_lo.i_cs,
         bus_lo.i_d, bus_lo.i_c, bus_lo.i_b, bus_lo.i_a} = v;
        {bus_hi.i_n_cs_1, bus_hi.i_n_cs_0, bus_hi.i_cs,
         bus_hi.i_d, bus_hi.i_c, bus_hi.i_b, bus_hi.i_a} = v;
        c = v[3:0];
        e = 10'h3FF;
        if (!r && v[4] && !v[5] && !v[6] && c < 4'd10) e[c] = 1'b0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] e;
        for (int i = 0; i < 3; i++) begin
            drive((i < 2), (i < 2) ? 7'($urandom_range(0, 127)) : 7'b0010100);
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL reset: scoreboard empty");
            end else begin
                e = exp_q.pop_front();
                checks++;
                if ({out_lo(), out_hi()} !== {e, ~e}) begin
                    failures++;
                    $display("FAIL reset step %0d: got lo=%b hi=%b want lo=%b hi=%b",
                             i, out_lo(), out_hi(), e, ~e);
                end
            end
        end
    endtask

    task automatic test_sweep_valid();
        logic [9:0] e;
        for (int c = 0; c < 16; c++) begin
            drive(1'b0, 7'(7'b0010000 | c));
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL decode: scoreboard empty");
            end else begin
                e = exp_q.pop_front();
                checks++;
                if ({out_lo(), out_hi()} !== {e, ~e}) begin
                    failures++;
                    $display("FAIL decode code=%0d: got lo=%b hi=%b want lo=%b hi=%b",
                             c, out_lo(), out_hi(), e, ~e);
                end
            end
        end
    endtask

    task automatic test_select_sweep();
        logic [9:0] e;
        for (int v = 0; v < 36; v++) begin
            drive(1'b0, 7'(v));
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL select: scoreboard empty");
            end else begin
                e = exp_q.pop_front();
                checks++;
                if ({out_lo(), out_hi()} !== {e, ~e}) begin
                    failures++;
                    $display("FAIL select v=%0d: got lo=%b hi=%b want lo=%b hi=%b",
                             v, out_lo(), out_hi(), e, ~e);
                end
                if ($countones(~out_lo()) > 1) begin
                    failures++;
                    $display("FAIL onehot v=%0d: got lo=%b want at most one low", v, out_lo());
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [9:0] e;
        logic       r_seq [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(r_seq[i], 7'b0010101);
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL mid_reset: scoreboard empty");
            end else begin
                e = exp_q.pop_front();
                checks++;
                if ({out_lo(), out_hi()} !== {e, ~e}) begin
                    failures++;
                    $display("FAIL mid_reset step %0d: got lo=%b hi=%b want lo=%b hi=%b",
                             i, out_lo(), out_hi(), e, ~e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] e;
        logic [6:0] seq [6] = '{7'b0010011, 7'b0010011, 7'b1010011,
                                7'b1010011, 7'b0010011, 7'b0011001};
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, seq[i]);
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL back_to_back: scoreboard empty");
            end else begin
                e = exp_q.pop_front();
                checks++;
                if ({out_lo(), out_hi()} !== {e, ~e}) begin
                    failures++;
                    $display("FAIL back_to_back step %0d: got lo=%b hi=%b want lo=%b hi=%b",
                             i, out_lo(), out_hi(), e, ~e);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [9:0] e;
        for (int i = 0; i < 40; i++) begin
            drive(($urandom_range(0, 9) == 0), 7'($urandom_range(0, 127)));
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL random: scoreboard empty");
            end else begin
                e = exp_q.pop_front();
                checks++;
                if ({out_lo(), out_hi()} !== {e, ~e}) begin
                    failures++;
                    $display("FAIL random step %0d: got lo=%b hi=%b want lo=%b hi=%b",
                             i, out_lo(), out_hi(), e, ~e);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        {bus_lo.i_n_cs_1, bus_lo.i_n_cs_0, bus_lo.i_cs,
         bus_lo.i_d, bus_lo.i_c, bus_lo.i_b, bus_lo.i_a} = '0;
        {bus_hi.i_n_cs_1, bus_hi.i_n_cs_0, bus_hi.i_cs,
         bus_hi.i_d, bus_hi.i_c, bus_hi.i_b, bus_hi.i_a} = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_sweep_valid();
        test_select_sweep();
        test_mid_reset();
        test_back_to_back();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
